// File: rtl/bitcnt_pipe.sv
// bitcnt_pipe: elastic, pipelined cpop / clz / ctz unit with an RV64 word mode.
//
// All three operations are folded into one population count:
//   cpop : count the ones of the (masked) operand.
//   ctz  : count the ones of ~x & (x - 1), i.e. the run of zeros below the
//          lowest set bit. For x == 0 that is every bit of the active field.
//   clz  : the same trick applied to the operand bit-reversed within N bits.
// The first pipeline stage produces per-byte counts. The remaining stages
// reduce them to the final count. Each stage carries a valid bit. A stage
// advances when the stage after it is empty or is advancing itself.
module bitcnt_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [WIDTH-1:0]       A,
  input  logic [1:0]             Op,
  input  logic                   W,
  input  logic                   Flush,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic [$clog2(WIDTH):0] Result
);

  localparam int RW    = $clog2(WIDTH) + 1;     // result width, holds WIDTH exactly
  localparam int NB    = WIDTH / 8;             // number of byte lanes
  localparam int NB_LO = (NB + 1) / 2;          // byte lanes in the low partial sum
  localparam int WSH   = (WIDTH >= 64) ? 32 : 0; // realigns the reversed word field

  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [RW-1:0]    ZERO_R = {RW{1'b0}};

  typedef enum logic [1:0] {
    OP_CPOP = 2'b00,
    OP_CLZ  = 2'b01,
    OP_CTZ  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  // Number of ones in one byte.
  function automatic logic [3:0] pop8(input logic [7:0] b);
    logic [3:0] acc;
    acc = 4'd0;
    for (int i = 0; i < 8; i++) begin
      acc = acc + {3'b000, b[i]};
    end
    return acc;
  endfunction

  // Sum of the byte counts in lanes [lo, hi).
  function automatic logic [RW-1:0] sum_range(input logic [NB-1:0][3:0] c,
                                              input int lo, input int hi);
    logic [RW-1:0] acc;
    acc = {RW{1'b0}};
    for (int i = 0; i < NB; i++) begin
      if (i >= lo && i < hi) begin
        acc = acc + RW'(c[i]);
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

  // Operand conditioning and per-byte counts. These feed stage 0.
  logic                   w_eff;
  logic [WIDTH-1:0]       field_mask;
  logic [WIDTH-1:0]       x_op;
  logic [WIDTH-1:0]       full_rev;
  logic [WIDTH-1:0]       rev_op;
  logic [WIDTH-1:0]       count_vec;
  logic [NB-1:0][3:0]     cnt_s;

  // Pipeline control.
  logic [STAGES-1:0]      valid_r;
  logic [STAGES-1:0]      take_s;
  logic [STAGES-1:0]      prev_s;
  logic [STAGES-1:0]      load_s;
  logic                   in_fire;
  logic [RW-1:0]          res_r;

  // Word mode exists only on 64-bit builds. Mask the active field and build X.
  always_comb begin
    w_eff      = (WIDTH >= 64) ? W : 1'b0;
    field_mask = ZERO_W;
    x_op       = ZERO_W;
    for (int i = 0; i < WIDTH; i++) begin
      field_mask[i] = ~w_eff | (i < 32);
      x_op[i]       = A[i] & field_mask[i];
    end
  end

  // Reverse X within the active N-bit field so that clz becomes ctz.
  always_comb begin
    full_rev = ZERO_W;
    for (int i = 0; i < WIDTH; i++) begin
      full_rev[i] = x_op[WIDTH-1-i];
    end
    rev_op = w_eff ? (full_rev >> WSH) : full_rev;
  end

  // Select the bit vector whose population equals the requested count.
  always_comb begin
    count_vec = ZERO_W;
    case (op_e'(Op))
      OP_CPOP: count_vec = x_op;
      OP_CLZ:  count_vec = ~rev_op & (rev_op - ONE_W) & field_mask;
      OP_CTZ:  count_vec = ~x_op & (x_op - ONE_W) & field_mask;
      default: count_vec = ZERO_W;
    endcase
  end

  // Per-byte population counts of the selected vector.
  always_comb begin
    cnt_s = {NB{4'd0}};
    for (int b = 0; b < NB; b++) begin
      cnt_s[b] = pop8(count_vec[8*b +: 8]);
    end
  end

  // A stage can take new contents when it or any stage downstream of it is empty.
  // It can also take them when the consumer is draining the last stage.
  always_comb begin : p_take
    logic chain_full;
    take_s = {STAGES{1'b0}};
    for (int i = 0; i < STAGES; i++) begin
      chain_full = 1'b1;
      for (int j = i; j < STAGES; j++) begin
        chain_full = chain_full & valid_r[j];
      end
      take_s[i] = OutReady | ~chain_full;
    end
  end

  assign InReady = ~reset & ~Flush & take_s[0];
  assign in_fire = InValid & InReady;

  // Each stage loads the valid bit of its upstream neighbour.
  // Data registers load only when that upstream valid is set.
  always_comb begin
    prev_s    = {STAGES{1'b0}};
    prev_s[0] = in_fire;
    for (int i = 1; i < STAGES; i++) begin
      prev_s[i] = valid_r[i-1];
    end
    load_s = take_s & prev_s;
  end

  // Stage valid bits. Reset and flush empty the whole pipe.
  always_ff @(posedge clk) begin
    if (reset || Flush) begin
      valid_r <= {STAGES{1'b0}};
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (take_s[i]) begin
          valid_r[i] <= prev_s[i];
        end else begin
          valid_r[i] <= valid_r[i];
        end
      end
    end
  end

  generate
    if (STAGES == 1) begin : g_one
      // The single stage registers the full sum taken directly from the byte counts.
      always_ff @(posedge clk) begin
        if (reset) begin
          res_r <= ZERO_R;
        end else if (load_s[0]) begin
          res_r <= sum_range(cnt_s, 0, NB);
        end else begin
          res_r <= res_r;
        end
      end
    end else if (STAGES == 2) begin : g_two
      logic [NB-1:0][3:0] cnt_r;

      // Stage 0 holds the byte counts.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_r <= {NB{4'd0}};
        end else if (load_s[0]) begin
          cnt_r <= cnt_s;
        end else begin
          cnt_r <= cnt_r;
        end
      end

      // The output stage adds the byte counts together.
      always_ff @(posedge clk) begin
        if (reset) begin
          res_r <= ZERO_R;
        end else if (load_s[1]) begin
          res_r <= sum_range(cnt_r, 0, NB);
        end else begin
          res_r <= res_r;
        end
      end
    end else begin : g_three
      logic [NB-1:0][3:0] cnt_r;
      logic [RW-1:0]      lo_r;
      logic [RW-1:0]      hi_r;

      // Stage 0 holds the byte counts.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_r <= {NB{4'd0}};
        end else if (load_s[0]) begin
          cnt_r <= cnt_s;
        end else begin
          cnt_r <= cnt_r;
        end
      end

      // Stage 1 reduces the byte counts to two partial sums, low half and high half.
      always_ff @(posedge clk) begin
        if (reset) begin
          lo_r <= ZERO_R;
          hi_r <= ZERO_R;
        end else if (load_s[1]) begin
          lo_r <= sum_range(cnt_r, 0, NB_LO);
          hi_r <= sum_range(cnt_r, NB_LO, NB);
        end else begin
          lo_r <= lo_r;
          hi_r <= hi_r;
        end
      end

      // The output stage adds the two partial sums.
      always_ff @(posedge clk) begin
        if (reset) begin
          res_r <= ZERO_R;
        end else if (load_s[2]) begin
          res_r <= lo_r + hi_r;
        end else begin
          res_r <= res_r;
        end
      end
    end
  endgenerate

  assign OutValid = valid_r[STAGES-1];
  assign Result   = res_r;

endmodule

// File: tb/tb_bitcnt_pipe.sv
// tb_bitcnt_pipe: directed checks for bitcnt_pipe.
// The main instance is 64-bit with two stages.
// Three narrow instances use widths 8, 16 and 32 with 1, 3 and 2 stages.
module tb_bitcnt_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        out_ready;

  logic        in_valid;
  logic        in_ready;
  logic [63:0] a_in;
  logic [1:0]  op_in;
  logic        w_in;
  logic        out_valid;
  logic [6:0]  result;

  logic        sm_valid;
  logic [63:0] sm_a;
  logic [1:0]  sm_op;
  logic        sm_w;
  logic        sm_rdy8, sm_rdy16, sm_rdy32;
  logic        sm_ov8, sm_ov16, sm_ov32;
  logic [3:0]  sm_res8;
  logic [4:0]  sm_res16;
  logic [5:0]  sm_res32;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bitcnt_pipe #(.WIDTH(64), .STAGES(2)) u_dut (
    .clk(clk), .reset(reset), .InValid(in_valid), .InReady(in_ready),
    .A(a_in), .Op(op_in), .W(w_in), .Flush(flush),
    .OutValid(out_valid), .OutReady(out_ready), .Result(result)
  );

  bitcnt_pipe #(.WIDTH(8), .STAGES(1)) u_w8 (
    .clk(clk), .reset(reset), .InValid(sm_valid), .InReady(sm_rdy8),
    .A(sm_a[7:0]), .Op(sm_op), .W(sm_w), .Flush(flush),
    .OutValid(sm_ov8), .OutReady(out_ready), .Result(sm_res8)
  );

  bitcnt_pipe #(.WIDTH(16), .STAGES(3)) u_w16 (
    .clk(clk), .reset(reset), .InValid(sm_valid), .InReady(sm_rdy16),
    .A(sm_a[15:0]), .Op(sm_op), .W(sm_w), .Flush(flush),
    .OutValid(sm_ov16), .OutReady(out_ready), .Result(sm_res16)
  );

  bitcnt_pipe #(.WIDTH(32), .STAGES(2)) u_w32 (
    .clk(clk), .reset(reset), .InValid(sm_valid), .InReady(sm_rdy32),
    .A(sm_a[31:0]), .Op(sm_op), .W(sm_w), .Flush(flush),
    .OutValid(sm_ov32), .OutReady(out_ready), .Result(sm_res32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Send one op into an empty pipe with OutReady=1.
  // Check that it appears exactly two cycles later, for one cycle only.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [1:0] op,
                        input logic w, input int exp);
    @(negedge clk);
    in_valid = 1'b1; a_in = a; op_in = op; w_in = w;
    #1 check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_ov_early"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check({tag, "_ov"}, 64'(out_valid), 64'd1);
    check({tag, "_res"}, 64'(result), 64'(exp));
    @(negedge clk);
    check({tag, "_ov_late"}, 64'(out_valid), 64'd0);
  endtask

  // Send one op to the three narrow instances.
  // Record the cycle in which each one presents its result.
  task automatic run_small(input string tag, input logic [1:0] op, input logic [63:0] a,
                           input int e8, input int e16, input int e32);
    int lat8, lat16, lat32;
    logic [63:0] r8, r16, r32;
    lat8 = 0; lat16 = 0; lat32 = 0;
    r8 = 64'd0; r16 = 64'd0; r32 = 64'd0;
    @(negedge clk);
    sm_valid = 1'b1; sm_op = op; sm_a = a;
    #1 check({tag, "_rdy"}, {61'd0, sm_rdy8, sm_rdy16, sm_rdy32}, 64'd7);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      sm_valid = 1'b0;
      if (sm_ov8)  begin lat8  = k; r8  = 64'(sm_res8);  end
      if (sm_ov16) begin lat16 = k; r16 = 64'(sm_res16); end
      if (sm_ov32) begin lat32 = k; r32 = 64'(sm_res32); end
    end
    check({tag, "_lat8"},  64'(lat8),  64'd1);
    check({tag, "_lat16"}, 64'(lat16), 64'd3);
    check({tag, "_lat32"}, 64'(lat32), 64'd2);
    check({tag, "_res8"},  r8,  64'(e8));
    check({tag, "_res16"}, r16, 64'(e16));
    check({tag, "_res32"}, r32, 64'(e32));
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; a_in = 64'd0; op_in = 2'b00; w_in = 1'b0;
    sm_valid = 1'b0; sm_a = 64'd0; sm_op = 2'b00; sm_w = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_ov", 64'(out_valid), 64'd0);
    check("rst_res", 64'(result), 64'd0);
    check("rst_rdy", 64'(in_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single ops: value and latency.
    run_op("cpop_basic", 64'hFFFF_0000_0000_00F1, 2'b00, 1'b0, 21);
    run_op("w_cpop",     64'hFFFF_FFFF_0000_0000, 2'b00, 1'b1, 0);
    run_op("w_clz",      64'hFFFF_FFFF_0000_0000, 2'b01, 1'b1, 32);
    run_op("w_ctz",      64'hFFFF_FFFF_0000_0000, 2'b10, 1'b1, 32);
    run_op("ctz",        64'hFFFF_FFFF_0000_0000, 2'b10, 1'b0, 32);
    run_op("clz",        64'hFFFF_FFFF_0000_0000, 2'b01, 1'b0, 0);
    run_op("cpop_ones",  64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0, 64);
    run_op("clz_zero",   64'h0000_0000_0000_0000, 2'b01, 1'b0, 64);
    run_op("ctz_zero",   64'h0000_0000_0000_0000, 2'b10, 1'b0, 64);
    run_op("rsvd",       64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0, 0);
    run_op("w_clz_1",    64'hFFFF_FFFF_0000_0001, 2'b01, 1'b1, 31);
    run_op("w_cpop_ones",64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b1, 32);
    run_op("ctz_msb",    64'h8000_0000_0000_0000, 2'b10, 1'b0, 63);
    run_op("w_ctz_hi",   64'h0000_0000_8000_0000, 2'b10, 1'b1, 31);
    run_op("clz_mid",    64'h0000_0100_0000_0000, 2'b01, 1'b0, 23);

    // Back-to-back streaming: clz of 1<<c gives 63-c, one result per cycle.
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("stream_ov", 64'(out_valid), (c >= 2 && c <= 9) ? 64'd1 : 64'd0);
      if (c >= 2 && c <= 9) check("stream_res", 64'(result), 64'(63 - (c - 2)));
      if (c < 8) begin
        in_valid = 1'b1; a_in = 64'd1 << c; op_in = 2'b01; w_in = 1'b0;
        #1 check("stream_rdy", 64'(in_ready), 64'd1);
      end else begin
        in_valid = 1'b0;
      end
    end

    // Backpressure: only two ops enter while OutReady is low.
    // The held Result stays stable, then both ops drain in order.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 2) check("bp_ov_empty", 64'(out_valid), 64'd0);
      if (c >= 2 && c <= 5) begin
        check("bp_ov_hold", 64'(out_valid), 64'd1);
        check("bp_res_hold", 64'(result), 64'd1);
      end
      if (c == 6) begin
        check("bp_ov_drain", 64'(out_valid), 64'd1);
        check("bp_res_drain", 64'(result), 64'd2);
      end
      if (c == 7) check("bp_ov_done", 64'(out_valid), 64'd0);
      if (c < 5) begin
        out_ready = 1'b0; in_valid = 1'b1; op_in = 2'b00; w_in = 1'b0;
        a_in = (64'd1 << (c + 1)) - 64'd1;
        #1 check("bp_rdy", 64'(in_ready), (c < 2) ? 64'd1 : 64'd0);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
      end
    end

    // Flush with two ops in flight and a concurrent InValid.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("fl_ov", 64'(out_valid), (c == 2) ? 64'd1 : 64'd0);
      if (c == 2) check("fl_res_xfer", 64'(result), 64'd4);
      if (c == 0) begin
        in_valid = 1'b1; a_in = 64'h10; op_in = 2'b10; w_in = 1'b0;
      end else if (c == 1) begin
        in_valid = 1'b1; a_in = 64'h10; op_in = 2'b01;
      end else if (c == 2) begin
        in_valid = 1'b1; a_in = 64'hFFFF_FFFF_FFFF_FFFF; op_in = 2'b00; flush = 1'b1;
        #1 check("fl_rdy", 64'(in_ready), 64'd0);
      end else begin
        in_valid = 1'b0; flush = 1'b0;
      end
    end
    run_op("post_flush", 64'h0000_0000_00FF_0000, 2'b10, 1'b0, 16);

    // Reset in the middle of a stream.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) begin
        check("mr_ov_before", 64'(out_valid), 64'd1);
        check("mr_res_before", 64'(result), 64'd2);
      end
      if (c == 3) check("mr_res", 64'(result), 64'd0);
      if (c >= 3) check("mr_ov", 64'(out_valid), 64'd0);
      if (c == 0) begin
        in_valid = 1'b1; a_in = 64'h4; op_in = 2'b10; w_in = 1'b0;
      end else if (c == 1) begin
        in_valid = 1'b1; a_in = 64'h4; op_in = 2'b01;
      end else if (c == 2) begin
        in_valid = 1'b0; reset = 1'b1;
        #1 check("mr_rdy", 64'(in_ready), 64'd0);
      end else begin
        reset = 1'b0;
      end
    end
    run_op("post_rst", 64'h0000_0000_0000_0F00, 2'b00, 1'b0, 4);

    // Narrow builds: W is ignored, and full-width results reach WIDTH.
    run_small("sm_cpop0", 2'b00, 64'h0, 0, 0, 0);
    run_small("sm_cpop1", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 8, 16, 32);
    run_small("sm_clz1",  2'b01, 64'h1, 7, 15, 31);
    run_small("sm_ctz0",  2'b10, 64'h0, 8, 16, 32);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
